// File: rtl/alu_display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_display_pkg
// Description : Shared constants for the ALU result display: digit count,
//               scan index width, blank/off patterns and hex-to-7-seg table.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_display_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int SCAN_W     = $clog2(NUM_DIGITS);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    // Segment patterns {g,f,e,d,c,b,a}, active-low; entry n is digit n.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // D
        7'b1000110,  // C
        7'b0000011,  // B
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return HEX_SEG[nibble];
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_result_display_debounce.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_display_debounce
// Description : Two-flop synchroniser plus counter-based debouncer for the
//               capture button. Provides the accepted level and a strobe that
//               is high in the cycle whose closing edge raises that level.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_result_display_debounce
    import alu_display_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_stable,
    output logic o_rise
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_btn_s;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             w_differs;
    logic             w_accept;

    assign w_differs = (r_btn_s != r_stable);
    assign w_accept  = w_differs && (r_cnt == c_CNT_LAST);

    // Bring the asynchronous button into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_btn_s <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_btn_s <= r_sync1;
        end
    end

    // Count consecutive disagreeing samples; adopt the new level once enough accumulate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else if (!w_differs) begin
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_stable <= r_btn_s;
        end else begin
            r_cnt    <= r_cnt + CNT_W'(1);
        end
    end

    assign o_stable = r_stable;
    assign o_rise   = w_accept & r_btn_s;

endmodule
`default_nettype wire

// File: rtl/alu_result_display.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_display
// Description : Latches the ALU result and function select on a debounced
//               button press and shows them on a 4-digit multiplexed
//               7-segment display (result low/high nibble, blank, op).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_result_display
    import alu_display_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REFRESH_CYCLES  = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] result,
    input  logic [2:0] op_sel,
    input  logic       btn_capture,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       captured
);

    localparam int REF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [REF_W-1:0] c_REF_LAST = REF_W'(REFRESH_CYCLES - 1);

    logic              w_stable;
    logic              w_rise;
    logic              r_stable_d;
    logic              r_captured;
    logic [5:0]        r_held_result;
    logic [2:0]        r_held_op;
    logic [REF_W-1:0]  r_refresh_cnt;
    logic [SCAN_W-1:0] r_scan_idx;
    logic [3:0]        r_an;
    logic [6:0]        r_seg;
    logic [3:0]        w_nibble;
    logic              w_blank;
    logic [3:0]        w_an_next;
    logic [6:0]        w_seg_next;

    alu_result_display_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_btn    (btn_capture),
        .o_stable (w_stable),
        .o_rise   (w_rise)
    );

    // Latch the ALU outputs on the edge where the debounced level rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_held_result <= '0;
            r_held_op     <= '0;
        end else if (w_rise) begin
            r_held_result <= result;
            r_held_op     <= op_sel;
        end
    end

    // One-cycle capture pulse in the cycle after the stable level first reads high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stable_d <= 1'b0;
            r_captured <= 1'b0;
        end else begin
            r_stable_d <= w_stable;
            r_captured <= w_stable & ~r_stable_d;
        end
    end

    // Refresh timer; each wrap moves the scan to the next digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_refresh_cnt <= '0;
            r_scan_idx    <= '0;
        end else if (r_refresh_cnt == c_REF_LAST) begin
            r_refresh_cnt <= '0;
            r_scan_idx    <= r_scan_idx + SCAN_W'(1);
        end else begin
            r_refresh_cnt <= r_refresh_cnt + REF_W'(1);
        end
    end

    // Select the nibble for the active digit and form the next anode/segment pattern.
    always_comb begin
        w_nibble = 4'h0;
        w_blank  = 1'b0;
        case (r_scan_idx)
            SCAN_W'(0): w_nibble = r_held_result[3:0];
            SCAN_W'(1): w_nibble = {2'b00, r_held_result[5:4]};
            SCAN_W'(2): w_blank  = 1'b1;
            default:    w_nibble = {1'b0, r_held_op};
        endcase
        w_seg_next = w_blank ? SEG_BLANK : hex_to_seg(w_nibble);
        w_an_next  = AN_OFF ^ (4'b0001 << r_scan_idx);
    end

    // Register anodes and segments together so both switch on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an  <= AN_OFF;
            r_seg <= SEG_BLANK;
        end else begin
            r_an  <= w_an_next;
            r_seg <= w_seg_next;
        end
    end

    assign an       = r_an;
    assign seg      = r_seg;
    assign dp       = 1'b1;
    assign captured = r_captured;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_result_display
// Description : Directed self-checking bench for alu_result_display with a
//               capture scoreboard (DEBOUNCE_CYCLES=4, REFRESH_CYCLES=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_result_display;

    typedef struct packed {
        logic [5:0] r;
        logic [2:0] o;
    } cap_t;

    logic       clk;
    logic       rst_n;
    logic [5:0] result;
    logic [2:0] op_sel;
    logic       btn_capture;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       captured;

    int   total;
    int   bad;
    int   cap_count;
    cap_t exp_q[$];
    cap_t last;

    alu_result_display #(
        .DEBOUNCE_CYCLES (4),
        .REFRESH_CYCLES  (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .result      (result),
        .op_sel      (op_sel),
        .btn_capture (btn_capture),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .captured    (captured)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count capture pulses seen at sample points.
    always @(negedge clk) begin
        if (captured === 1'b1) cap_count++;
    end

    function automatic logic [6:0] bhex(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_capture();
        int n;
        n = 0;
        while (captured !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("capture_seen", {31'd0, captured}, 32'd1);
        last = exp_q.pop_front();
    endtask

    task automatic check_display(input cap_t e);
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        int n;
        for (int k = 0; k < 4; k++) begin
            exp_an = 4'b1111 ^ (4'b0001 << k);
            case (k)
                0:       exp_seg = bhex(e.r[3:0]);
                1:       exp_seg = bhex({2'b00, e.r[5:4]});
                2:       exp_seg = 7'b1111111;
                default: exp_seg = bhex({1'b0, e.o});
            endcase
            n = 0;
            while (an !== exp_an && n < 16) begin
                @(negedge clk);
                n++;
            end
            chk($sformatf("disp_an%0d", k), {28'd0, an}, {28'd0, exp_an});
            chk($sformatf("disp_seg%0d", k), {25'd0, seg}, {25'd0, exp_seg});
        end
    endtask

    initial begin
        cap_t e;
        logic [3:0] exp_an;
        total       = 0;
        bad         = 0;
        cap_count   = 0;
        rst_n       = 1'b0;
        result      = 6'd0;
        op_sel      = 3'd0;
        btn_capture = 1'b0;

        // Reset state
        cycles(3);
        chk("rst_an", {28'd0, an}, 32'hF);
        chk("rst_seg", {25'd0, seg}, 32'h7F);
        chk("rst_dp", {31'd0, dp}, 32'd1);
        chk("rst_captured", {31'd0, captured}, 32'd0);

        // Scan timing from reset release: three cycles per digit
        rst_n = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            exp_an = 4'b1111 ^ (4'b0001 << (((k - 1) / 3) % 4));
            chk($sformatf("scan_an_k%0d", k), {28'd0, an}, {28'd0, exp_an});
            chk($sformatf("scan_seg_k%0d", k), {25'd0, seg},
                (((k - 1) / 3) % 4 == 2) ? 32'h7F : 32'h40);
        end

        // Clean capture with exact latency
        result = 6'b101101;
        op_sel = 3'b011;
        e.r = result; e.o = op_sel;
        exp_q.push_back(e);
        btn_capture = 1'b1;
        cycles(6);
        chk("lat_cyc6", {31'd0, captured}, 32'd0);
        cycles(1);
        chk("lat_cyc7", {31'd0, captured}, 32'd1);
        last = exp_q.pop_front();
        cycles(1);
        chk("lat_cyc8", {31'd0, captured}, 32'd0);
        check_display(last);
        btn_capture = 1'b0;
        cycles(12);
        chk("count_after_clean", cap_count, 32'd1);

        // Bounce rejection; inputs change without a capture
        result = 6'h12;
        op_sel = 3'd5;
        for (int i = 0; i < 4; i++) begin
            btn_capture = ~i[0];
            cycles(2);
        end
        btn_capture = 1'b0;
        cycles(15);
        chk("count_after_bounce", cap_count, 32'd1);
        check_display(last);

        // Long hold with the result changing after capture
        result = 6'h3F;
        op_sel = 3'd3;
        e.r = result; e.o = op_sel;
        exp_q.push_back(e);
        btn_capture = 1'b1;
        wait_capture();
        result = 6'h00;
        op_sel = 3'd0;
        cycles(90);
        btn_capture = 1'b0;
        cycles(12);
        chk("count_after_hold", cap_count, 32'd2);
        check_display(last);

        // Reset in the middle of debouncing with the button still held
        result = 6'h27;
        op_sel = 3'b110;
        btn_capture = 1'b1;
        cycles(4);
        rst_n = 1'b0;
        #1;
        chk("async_rst_an", {28'd0, an}, 32'hF);
        chk("async_rst_seg", {25'd0, seg}, 32'h7F);
        chk("async_rst_dp", {31'd0, dp}, 32'd1);
        chk("async_rst_captured", {31'd0, captured}, 32'd0);
        cycles(2);
        e.r = result; e.o = op_sel;
        exp_q.push_back(e);
        rst_n = 1'b1;
        cycles(6);
        chk("rst_lat_cyc6", {31'd0, captured}, 32'd0);
        cycles(1);
        chk("rst_lat_cyc7", {31'd0, captured}, 32'd1);
        last = exp_q.pop_front();
        check_display(last);
        btn_capture = 1'b0;
        cycles(12);
        chk("count_final", cap_count, 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
